// File: rtl/nes_alu.sv
// NES-style 8-bit ALU with a single registered result stage.
// Flags follow the 6502 P-register layout: C, Z, V and N.
module nes_alu (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] alu_a,
    input  logic [7:0] alu_b,
    input  logic [4:0] mode,
    input  logic       carry_in,
    output logic [7:0] alu_out,
    output logic       carry_out,
    output logic       overflow,
    output logic       zero,
    output logic       sign
);

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_AND = 5'd1;
    localparam logic [4:0] OP_OR  = 5'd2;
    localparam logic [4:0] OP_EOR = 5'd3;
    localparam logic [4:0] OP_SR  = 5'd4;
    localparam logic [4:0] OP_SUB = 5'd5;

    logic [8:0] add_sum;
    logic [8:0] sub_sum;
    logic       add_v;
    logic       sub_v;
    logic [7:0] res;
    logic       res_c;
    logic       res_v;

    // SUB reuses the adder form: a + ~b + cin, where cin=1 means no borrow
    assign add_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, carry_in};
    assign sub_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'd0, carry_in};

    assign add_v = (alu_a[7] == alu_b[7]) && (add_sum[7] != alu_a[7]);
    assign sub_v = (alu_a[7] != alu_b[7]) && (sub_sum[7] != alu_a[7]);

    always_comb begin
        res   = alu_a;
        res_c = 1'b0;
        res_v = 1'b0;
        unique case (mode)
            OP_ADD: begin
                res   = add_sum[7:0];
                res_c = add_sum[8];
                res_v = add_v;
            end
            OP_AND: res = alu_a & alu_b;
            OP_OR:  res = alu_a | alu_b;
            OP_EOR: res = alu_a ^ alu_b;
            OP_SR: begin
                res   = {carry_in, alu_a[7:1]};
                res_c = alu_a[0];
            end
            OP_SUB: begin
                res   = sub_sum[7:0];
                res_c = sub_sum[8];
                res_v = sub_v;
            end
            default: begin
                res   = alu_a;
                res_c = 1'b0;
                res_v = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            alu_out   <= 8'h00;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            sign      <= 1'b0;
        end else begin
            alu_out   <= res;
            carry_out <= res_c;
            overflow  <= res_v;
            zero      <= (res == 8'h00);
            sign      <= res[7];
        end
    end

endmodule

// File: tb/tb_nes_alu.sv
// Directed and randomized checks of nes_alu against an
// integer-arithmetic reference model.
module tb_nes_alu;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [4:0] mode;
    logic       carry_in;
    logic [7:0] alu_out;
    logic       carry_out;
    logic       overflow;
    logic       zero;
    logic       sign;

    int checks = 0;
    int errors = 0;

    nes_alu dut (
        .clk      (clk),
        .reset    (reset),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .mode     (mode),
        .carry_in (carry_in),
        .alu_out  (alu_out),
        .carry_out(carry_out),
        .overflow (overflow),
        .zero     (zero),
        .sign     (sign)
    );

    always #5 clk = ~clk;

    function automatic int to_signed8(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Packed as {out[7:0], C, V, Z, N}
    function automatic logic [11:0] model(input int m, input int a,
                                          input int b, input int cin);
        int s;
        int sr;
        int o;
        int c;
        int v;
        c = 0;
        v = 0;
        case (m)
            0: begin
                s  = a + b + cin;
                o  = s % 256;
                c  = (s > 255) ? 1 : 0;
                sr = to_signed8(a) + to_signed8(b) + cin;
                v  = (sr > 127 || sr < -128) ? 1 : 0;
            end
            1: o = a & b;
            2: o = a | b;
            3: o = a ^ b;
            4: begin
                o = a / 2 + cin * 128;
                c = a % 2;
            end
            5: begin
                s  = a + (255 - b) + cin;
                o  = s % 256;
                c  = (s > 255) ? 1 : 0;
                sr = to_signed8(a) - to_signed8(b) - (1 - cin);
                v  = (sr > 127 || sr < -128) ? 1 : 0;
            end
            default: o = a;
        endcase
        return {o[7:0], c[0], v[0], (o == 0), (o >= 128)};
    endfunction

    task automatic step(input string tag, input logic rst, input int m,
                        input int a, input int b, input int cin);
        logic [11:0] exp;
        logic [11:0] obs;
        reset    = rst;
        mode     = m[4:0];
        alu_a    = a[7:0];
        alu_b    = b[7:0];
        carry_in = cin[0];
        exp = rst ? model(m, a, b, cin) : 12'h000;
        @(posedge clk);
        #1;
        obs = {alu_out, carry_out, overflow, zero, sign};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s m=%0d a=%h b=%h cin=%0d obs=%h exp=%h",
                   tag, m, a, b, cin, obs, exp);
        end
    endtask

    initial begin
        reset    = 1'b0;
        alu_a    = 8'hFF;
        alu_b    = 8'hFF;
        mode     = 5'd0;
        carry_in = 1'b1;

        step("reset0", 1'b0, 0, 8'hFF, 8'hFF, 1);
        step("reset1", 1'b0, 5, 8'h12, 8'h34, 0);

        step("add_50_50", 1'b1, 0, 8'h50, 8'h50, 0);
        step("add_ff_01", 1'b1, 0, 8'hFF, 8'h01, 0);
        step("sub_05_06", 1'b1, 5, 8'h05, 8'h06, 1);
        step("sub_80_01", 1'b1, 5, 8'h80, 8'h01, 1);
        step("sr_03", 1'b1, 4, 8'h03, 8'h5A, 1);
        step("and_f0_0f", 1'b1, 1, 8'hF0, 8'h0F, 1);
        step("eor_aa_ff", 1'b1, 3, 8'hAA, 8'hFF, 0);
        step("or_a0_05", 1'b1, 2, 8'hA0, 8'h05, 1);
        step("add_ff_ff_c", 1'b1, 0, 8'hFF, 8'hFF, 1);
        step("sub_00_00_b", 1'b1, 5, 8'h00, 8'h00, 0);
        step("mode6", 1'b1, 6, 8'h9C, 8'h11, 1);
        step("mode31", 1'b1, 31, 8'h00, 8'hFF, 1);

        // Stream of ADDs with reset dropped mid-stream
        step("stream0", 1'b1, 0, 8'h10, 8'h20, 0);
        step("stream1", 1'b1, 0, 8'h7F, 8'h01, 0);
        step("stream_rst", 1'b0, 0, 8'hFF, 8'h01, 0);
        step("stream_rel", 1'b1, 0, 8'h33, 8'h44, 1);
        step("stream2", 1'b1, 0, 8'h80, 8'h80, 0);

        for (int i = 0; i < 400; i++) begin
            int m;
            m = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31)
                                            : $urandom_range(0, 5);
            step("rand", ($urandom_range(0, 30) != 0), m,
                 $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 1));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
